// File: rtl/rx2in_ctl_pkg.sv
// ---------------------------------------------------------------------------
// rx2in_ctl_pkg
// Shared definitions for the UART-RX -> CPU INBOX path:
//   - controller FSM state encoding
//   - default buffer sizing
//   - pointer-width helper used by the buffer FIFO
// No ports; imported by rx2in_ctl and rx2in_ctl_fifo.
// ---------------------------------------------------------------------------
package rx2in_ctl_pkg;

  localparam int unsigned RX2IN_DEPTH_DEF      = 16;
  localparam int unsigned RX2IN_RTS_MARGIN_DEF = 4;

  // 2'd3 is unused; the FSM recovers from it to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_SETTLE = 2'd2
  } rx2in_state_e;

  // Read/write pointer width for a FIFO of the given depth (at least 1 bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rx2in_ctl_fifo.sv
// ---------------------------------------------------------------------------
// rx2in_ctl_fifo
// Synchronous single-clock FIFO with occupancy count and a registered
// head-data output (loaded on pop). Written generically so it can also sit
// in front of the outbox later.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset (empties the FIFO)
//   push       in   write request; accepted when not full, or when full and
//                   a pop happens in the same cycle
//   push_data  in   [7:0] byte to store
//   pop        in   read request; ignored when empty
//   pop_data   out  [7:0] byte removed by the most recent pop (0 after reset)
//   level      out  [$clog2(DEPTH):0] occupancy, 0..DEPTH
//   full       out  level == DEPTH
//   empty      out  level == 0
// ---------------------------------------------------------------------------
module rx2in_ctl_fifo
  import rx2in_ctl_pkg::*;
#(
  parameter int unsigned DEPTH = RX2IN_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  // When full, a same-cycle pop frees the slot being written: wr_ptr equals
  // rd_ptr, and the non-blocking read below still sees the old byte.
  assign push_ok = push && (!full || pop_ok);

  // Storage is left unreset so it can map onto a register-file/RAM macro.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      pop_data <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        pop_data <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rx2in_ctl.sv
// ---------------------------------------------------------------------------
// rx2in_ctl
// Moves bytes from the UART receiver into the CPU INBOX. Received bytes are
// buffered in a FIFO so nothing is lost while the INBOX is full; INBOX writes
// are paced to one every three cycles so the INBOX full flag can settle
// between writes. Bytes arriving while the FIFO is full are dropped and
// counted.
//
// Optional feature, macro RX2IN_FLOWCTL_EN:
//   defined   -> o_rts_n port present; registered active-low ready-to-send,
//                high (stop) once free entries fall to RTS_MARGIN or fewer.
//   undefined -> no o_rts_n port and no flow-control logic.
//
// Ports
//   clk         in   system clock
//   i_rst       in   synchronous active-high reset
//   i_rx_wr     in   one-cycle strobe, i_rx_data valid
//   i_rx_data   in   [7:0] received byte
//   i_in_full   in   CPU INBOX full
//   o_in_wr     out  one-cycle INBOX write strobe
//   o_in_data   out  [7:0] byte for the INBOX, valid while o_in_wr=1
//   o_level     out  [$clog2(DEPTH):0] FIFO occupancy, 0..DEPTH
//   o_overflow  out  sticky, a byte was dropped since reset
//   o_drop_cnt  out  [7:0] dropped-byte count, saturates at 255
//   o_rts_n     out  flow control (RX2IN_FLOWCTL_EN only)
//
// FSM states
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | waiting for a buffered byte and a non-full INBOX; pops
//             | the FIFO head on the transition to ST_WRITE
//   ST_WRITE  | o_in_wr high for exactly this cycle
//   ST_SETTLE | o_in_wr low; gives the INBOX full flag a cycle to update
// ---------------------------------------------------------------------------
module rx2in_ctl
  import rx2in_ctl_pkg::*;
#(
  parameter int unsigned DEPTH      = RX2IN_DEPTH_DEF,
  parameter int unsigned RTS_MARGIN = RX2IN_RTS_MARGIN_DEF
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_rx_wr,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_in_full,
  output logic                     o_in_wr,
  output logic [7:0]               o_in_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  output logic [7:0]               o_drop_cnt
`ifdef RX2IN_FLOWCTL_EN
  ,
  output logic                     o_rts_n
`endif
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  // Elaboration-time sanity checks on the sizing parameters.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("rx2in_ctl: DEPTH must be a power of two and at least 2");
  end
  if ((RTS_MARGIN < 1) || (RTS_MARGIN > DEPTH - 1)) begin : g_bad_margin
    $error("rx2in_ctl: RTS_MARGIN must be in 1..DEPTH-1");
  end

  rx2in_state_e state;

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic drop;

  // Pop is taken straight from the registered state so the head byte lands
  // in o_in_data on the same edge that raises o_in_wr.
  assign pop  = (state == ST_IDLE) && !fifo_empty && !i_in_full;
  assign drop = i_rx_wr && fifo_full && !pop;

  rx2in_ctl_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (i_rst),
    .push      (i_rx_wr),
    .push_data (i_rx_data),
    .pop       (pop),
    .pop_data  (o_in_data),
    .level     (o_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Once a byte is popped the write is committed: a late rise of i_in_full
  // in WRITE/SETTLE does not cancel it. Only reset abandons it.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      o_in_wr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state   <= ST_WRITE;
            o_in_wr <= 1'b1;
          end else begin
            o_in_wr <= 1'b0;
          end
        end
        ST_WRITE: begin
          state   <= ST_SETTLE;
          o_in_wr <= 1'b0;
        end
        ST_SETTLE: begin
          state   <= ST_IDLE;
          o_in_wr <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          o_in_wr <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (o_drop_cnt != 8'hFF) begin
        o_drop_cnt <= o_drop_cnt + 8'd1;
      end
    end
  end

`ifdef RX2IN_FLOWCTL_EN
  logic [LVL_W-1:0] free_cnt;

  assign free_cnt = LVL_W'(DEPTH) - o_level;

  // Derived from the registered level, so it follows one cycle behind it.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_rts_n <= 1'b0;
    end else begin
      o_rts_n <= (free_cnt <= LVL_W'(RTS_MARGIN));
    end
  end
`endif

endmodule

// File: tb/tb_rx2in_ctl.sv
// Testbench for rx2in_ctl: directed scenarios followed by randomized traffic,
// checked against a queue-based reference model through a scoreboard.
module tb_rx2in_ctl;

  localparam int DEPTH      = 16;
  localparam int RTS_MARGIN = 4;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_rx_wr;
  logic [7:0] i_rx_data;
  logic       i_in_full;
  logic       o_in_wr;
  logic [7:0] o_in_data;
  logic [$clog2(DEPTH):0] o_level;
  logic       o_overflow;
  logic [7:0] o_drop_cnt;
`ifdef RX2IN_FLOWCTL_EN
  logic       o_rts_n;
`endif

  always #5 clk = ~clk;

  rx2in_ctl #(
    .DEPTH      (DEPTH),
    .RTS_MARGIN (RTS_MARGIN)
  ) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_rx_wr    (i_rx_wr),
    .i_rx_data  (i_rx_data),
    .i_in_full  (i_in_full),
    .o_in_wr    (o_in_wr),
    .o_in_data  (o_in_data),
    .o_level    (o_level),
    .o_overflow (o_overflow),
    .o_drop_cnt (o_drop_cnt)
`ifdef RX2IN_FLOWCTL_EN
    ,
    .o_rts_n    (o_rts_n)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: buffered bytes, cycles until the next INBOX write may
  // start, and the expected values of the status outputs.
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  int  m_gap  = 0;
  bit  m_wr   = 1'b0;
  bit  m_ovf  = 1'b0;
  int  m_drop = 0;
  bit  m_rts  = 1'b0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge of the spec's behaviour, from the inputs being applied.
  function automatic void model_edge();
    bit pop;
    int sz;
    if (i_rst) begin
      m_q.delete();
      m_gap  = 0;
      m_wr   = 1'b0;
      m_ovf  = 1'b0;
      m_drop = 0;
      m_rts  = 1'b0;
      return;
    end
    sz    = m_q.size();
    pop   = (m_gap == 0) && (sz > 0) && !i_in_full;
    m_rts = (DEPTH - sz) <= RTS_MARGIN;
    if (pop) begin
      exp_q.push_back(m_q.pop_front());
      m_gap = 2;
    end else if (m_gap > 0) begin
      m_gap--;
    end
    if (i_rx_wr) begin
      if (sz < DEPTH || pop) begin
        m_q.push_back(i_rx_data);
      end else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    m_wr = pop;
  endfunction

  task automatic cycle(input bit rst, input bit wr, input logic [7:0] d, input bit full);
    i_rst     = rst;
    i_rx_wr   = wr;
    i_rx_data = d;
    i_in_full = full;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Monitor: compares every cycle, pops the scoreboard on each INBOX write.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_wr", int'(o_in_wr), int'(m_wr));
      if (o_in_wr) begin
        if (exp_q.size() == 0) begin
          chk("in_data_expected_count", exp_q.size(), 1);
        end else begin
          chk("in_data", int'(o_in_data), int'(exp_q.pop_front()));
        end
      end else if (m_wr && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
      chk("level", int'(o_level), m_q.size());
      chk("overflow", int'(o_overflow), int'(m_ovf));
      chk("drop_cnt", int'(o_drop_cnt), m_drop);
`ifdef RX2IN_FLOWCTL_EN
      chk("rts_n", int'(o_rts_n), int'(m_rts));
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit full_r;
    i_rst = 1'b1; i_rx_wr = 1'b0; i_rx_data = 8'h00; i_in_full = 1'b0;
    cycle(1, 0, 8'h00, 0);
    mon_en = 1'b1;
    cycle(1, 0, 8'h00, 0);
    chk("rst_in_wr", int'(o_in_wr), 0);
    chk("rst_in_data", int'(o_in_data), 0);
    chk("rst_level", int'(o_level), 0);
    chk("rst_overflow", int'(o_overflow), 0);
    chk("rst_drop_cnt", int'(o_drop_cnt), 0);

    // T1: single byte, write appears two cycles after the strobe.
    cycle(0, 1, 8'h41, 0);
    chk("t1_wr_n1", int'(o_in_wr), 0);
    cycle(0, 0, 8'h00, 0);
    chk("t1_wr_n2", int'(o_in_wr), 1);
    chk("t1_data_n2", int'(o_in_data), 8'h41);
    cycle(0, 0, 8'h00, 0);
    chk("t1_wr_n3", int'(o_in_wr), 0);
    chk("t1_level", int'(o_level), 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 0);

    // T2: backpressure, then in-order paced drain.
    for (int i = 1; i <= 5; i++) cycle(0, 1, 8'(i), 1);
    cycle(0, 0, 8'h00, 1);
    chk("t2_level", int'(o_level), 5);
    chk("t2_no_wr", int'(o_in_wr), 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 8'h00, 0);
    chk("t2_level_drained", int'(o_level), 0);

    // T3: overflow, two bytes dropped.
    for (int i = 0; i < 18; i++) cycle(0, 1, 8'(8'h10 + i), 1);
    cycle(0, 0, 8'h00, 1);
    chk("t3_level", int'(o_level), 16);
    chk("t3_overflow", int'(o_overflow), 1);
    chk("t3_drop_cnt", int'(o_drop_cnt), 2);

    // T4: push at full coincides with a pop and is accepted.
    cycle(0, 1, 8'hAA, 0);
    chk("t4_level", int'(o_level), 16);
    chk("t4_drop_cnt", int'(o_drop_cnt), 2);
    chk("t4_wr", int'(o_in_wr), 1);
    for (int i = 0; i < 60; i++) cycle(0, 0, 8'h00, 0);
    chk("t4_level_drained", int'(o_level), 0);

    // T5: reset while in WRITE with three bytes buffered.
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'(8'hC0 + i), 1);
    cycle(0, 0, 8'h00, 0);
    chk("t5_pre_wr", int'(o_in_wr), 1);
    chk("t5_pre_level", int'(o_level), 3);
    cycle(1, 0, 8'h00, 0);
    chk("t5_wr", int'(o_in_wr), 0);
    chk("t5_level", int'(o_level), 0);
    chk("t5_overflow", int'(o_overflow), 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 8'h00, 0);

`ifdef RX2IN_FLOWCTL_EN
    // T6: RTS asserts one cycle after level reaches 12, releases after 11.
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 12; i++) cycle(0, 1, 8'(8'h60 + i), 1);
    chk("t6_rts_lag", int'(o_rts_n), 0);
    cycle(0, 0, 8'h00, 1);
    chk("t6_rts_stop", int'(o_rts_n), 1);
    cycle(0, 0, 8'h00, 0);
    chk("t6_level_11", int'(o_level), 11);
    cycle(0, 0, 8'h00, 1);
    chk("t6_rts_go", int'(o_rts_n), 0);
    for (int i = 0; i < 40; i++) cycle(0, 0, 8'h00, 0);
`endif

    // Randomized traffic with bursty INBOX backpressure and rare resets.
    cycle(1, 0, 8'h00, 0);
    full_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) full_r = ~full_r;
      cycle(($urandom_range(0, 399) == 0), ($urandom_range(0, 2) != 0),
            8'($urandom), full_r);
    end

    // Drain, bounded.
    for (int i = 0; i < 200 && m_q.size() != 0; i++) cycle(0, 0, 8'h00, 0);
    chk("drain_model_empty", m_q.size(), 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 0);
    chk("drain_level", int'(o_level), 0);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
